// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the fetch/data SRAM port arbiter:
//   - owner encoding of the access whose read data returns next cycle
//   - arbitration mode encoding
//   - active-low SRAM control levels
//   - helper that derives the next owner from this cycle's grant
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int WAIT_W = 4;

  // SRAM CSN/WEN are active low.
  localparam logic SRAM_ON  = 1'b0;
  localparam logic SRAM_OFF = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DR   = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_D   = 1'b0,
    FORCE_I = 1'b1
  } mode_e;

  // Only reads produce a return; a data write leaves the owner empty.
  function automatic owner_e owner_next(input logic i_gnt,
                                        input logic d_gnt,
                                        input logic d_we);
    if (i_gnt)
      return OWN_I;
    else if (d_gnt && !d_we)
      return OWN_DR;
    else
      return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// ----------------------------------------------------------------------------
// mem_arb_stats
//   Free-running performance counters for the SRAM port arbiter. Each counter
//   adds one per qualifying cycle and wraps at 2^CWIDTH.
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   i_gnt        in   fetch granted this cycle
//   d_gnt        in   data granted this cycle
//   i_stall      in   fetch requested but not granted this cycle
//   i_cnt        out  granted fetches
//   d_cnt        out  granted data accesses
//   i_stall_cnt  out  fetch stall cycles
// ----------------------------------------------------------------------------
module mem_arb_stats #(
  parameter int CWIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_gnt,
  input  logic              d_gnt,
  input  logic              i_stall,
  output logic [CWIDTH-1:0] i_cnt,
  output logic [CWIDTH-1:0] d_cnt,
  output logic [CWIDTH-1:0] i_stall_cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_cnt       <= '0;
      d_cnt       <= '0;
      i_stall_cnt <= '0;
    end else begin
      if (i_gnt)   i_cnt       <= i_cnt + 1'b1;
      if (d_gnt)   d_cnt       <= d_cnt + 1'b1;
      if (i_stall) i_stall_cnt <= i_stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous SRAM between the instruction-fetch port
//   (I) and the data port (D). One grant per cycle at most, decided
//   combinationally from the requests and the registered mode. Data has fixed
//   priority; after MAX_WAIT-1 consecutive denied fetch cycles the mode
//   switches to FORCE_I so fetch wins the next cycle. Read data returns one
//   cycle after grant on the port that owned the access.
//
// Ports
//   CLK, RST                       clock / async active-high reset
//   I_REQ, I_ADDR                  fetch request and word address
//   I_GNT, I_RVALID, I_RDATA       fetch grant, return valid, return data
//   D_REQ, D_WE, D_ADDR, D_BE,
//   D_WDATA                        data request, write flag, address, byte
//                                  enables, write data
//   D_GNT, D_RVALID, D_RDATA       data grant, read return valid and data
//   M_CSN, M_WEN, M_ADDR, M_BE,
//   M_DI, M_DOUT                   SRAM interface (active-low CSN/WEN)
//   I_CNT, D_CNT, I_STALL_CNT      wrapping performance counters
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH   = 10,
  parameter int MAX_WAIT = 4,
  parameter int CWIDTH   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // fetch port
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DATA_W-1:0] I_RDATA,
  // data port
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [BE_W-1:0]   D_BE,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  // SRAM
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [BE_W-1:0]   M_BE,
  output logic [DATA_W-1:0] M_DI,
  input  logic [DATA_W-1:0] M_DOUT,
  // statistics
  output logic [CWIDTH-1:0] I_CNT,
  output logic [CWIDTH-1:0] D_CNT,
  output logic [CWIDTH-1:0] I_STALL_CNT
);

  // The mode flips once the wait counter would reach this value, so the
  // fetch is served no later than its MAX_WAIT-th requested cycle.
  localparam int FORCE_AT = MAX_WAIT - 1;

  mode_e             mode_q, mode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  owner_e            owner_q;
  logic              i_gnt, d_gnt, d_wr, i_stall;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  // --------------------------------------------------------------------------
  // Arbitration FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= PRI_D;
      wait_q <= '0;
    end else begin
      mode_q <= mode_d;
      wait_q <= wait_d;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mode_d = mode_q;
    wait_d = i_stall ? wait_q + 1'b1 : '0;
    case (mode_q)
      PRI_D:   if (i_stall && (int'(wait_q) + 1 >= FORCE_AT)) mode_d = FORCE_I;
      FORCE_I: if (i_gnt || !I_REQ) mode_d = PRI_D;
      default: mode_d = PRI_D;
    endcase
  end

  // --------------------------------------------------------------------------
  // Arbitration FSM: outputs (grants). Held off while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RST) begin
      case (mode_q)
        PRI_D: begin
          d_gnt = D_REQ;
          i_gnt = I_REQ & ~D_REQ;
        end
        FORCE_I: begin
          i_gnt = I_REQ;
          d_gnt = D_REQ & ~I_REQ;
        end
        default: ;
      endcase
    end
  end

  assign i_stall = I_REQ & ~i_gnt;
  assign d_wr    = d_gnt & D_WE;

  // --------------------------------------------------------------------------
  // SRAM drive. With no grant the address/data paths default to the I side;
  // CSN high makes them don't-care.
  // --------------------------------------------------------------------------
  assign M_CSN  = (i_gnt || d_gnt) ? SRAM_ON : SRAM_OFF;
  assign M_WEN  = d_wr ? SRAM_ON : SRAM_OFF;
  assign M_ADDR = d_gnt ? D_ADDR : I_ADDR;
  assign M_BE   = d_wr ? D_BE : '0;
  assign M_DI   = D_WDATA;

  // --------------------------------------------------------------------------
  // Read return: the owner register tags the access issued at the last edge.
  // Reset clears it asynchronously, discarding any in-flight read.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) owner_q <= OWN_NONE;
    else     owner_q <= owner_next(i_gnt, d_gnt, D_WE);
  end

  assign I_RVALID = (owner_q == OWN_I);
  assign D_RVALID = (owner_q == OWN_DR);

  // Each port keeps showing its last returned word while another port owns
  // the SRAM output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (I_RVALID) i_rdata_q <= M_DOUT;
      if (D_RVALID) d_rdata_q <= M_DOUT;
    end
  end

  assign I_RDATA = I_RVALID ? M_DOUT : i_rdata_q;
  assign D_RDATA = D_RVALID ? M_DOUT : d_rdata_q;

  assign I_GNT = i_gnt;
  assign D_GNT = d_gnt;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  mem_arb_stats #(
    .CWIDTH (CWIDTH)
  ) u_stats (
    .CLK         (CLK),
    .RST         (RST),
    .i_gnt       (i_gnt),
    .d_gnt       (d_gnt),
    .i_stall     (i_stall),
    .i_cnt       (I_CNT),
    .d_cnt       (D_CNT),
    .i_stall_cnt (I_STALL_CNT)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural SRAM. Stimulus
//   pushes hand-computed read data into per-port queues at grant time; a
//   monitor pops and compares whenever a port raises RVALID. Counters use a
//   4-bit width so the wrap boundary is reachable.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int CW = 4;
  localparam int MW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ, D_REQ, D_WE;
  logic [AW-1:0] I_ADDR, D_ADDR;
  logic [3:0]    D_BE;
  logic [31:0]   D_WDATA;
  logic          I_GNT, I_RVALID, D_GNT, D_RVALID;
  logic [31:0]   I_RDATA, D_RDATA;
  logic          M_CSN, M_WEN;
  logic [AW-1:0] M_ADDR;
  logic [3:0]    M_BE;
  logic [31:0]   M_DI, M_DOUT;
  logic [CW-1:0] I_CNT, D_CNT, I_STALL_CNT;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AWIDTH(AW), .MAX_WAIT(MW), .CWIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI), .M_DOUT(M_DOUT),
    .I_CNT(I_CNT), .D_CNT(D_CNT), .I_STALL_CNT(I_STALL_CNT)
  );

  // Behavioural single-port SRAM; preloaded while load_en is high.
  logic        load_en;
  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge CLK) begin
    if (load_en) begin
      for (int a = 0; a < (1 << AW); a++)
        mem[a] <= (a < 8) ? 32'h100 + a : (a == 'h3A5) ? 32'h1122_3344 : 32'h0;
    end else if (!M_CSN) begin
      if (!M_WEN)
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
      M_DOUT <= mem[M_ADDR];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares returned data against the queued expectations.
  always @(negedge CLK) begin
    if (!RST) begin
      if (I_RVALID) begin
        if (i_q.size() == 0) check("i_rvalid_unexpected", 32'(I_RVALID), 32'd0);
        else check("i_rdata", I_RDATA, i_q.pop_front());
      end
      if (D_RVALID) begin
        if (d_q.size() == 0) check("d_rvalid_unexpected", 32'(D_RVALID), 32'd0);
        else check("d_rdata", D_RDATA, d_q.pop_front());
      end
    end
  end

  // Drive one cycle (called at posedge+1), check grant and SRAM drive at
  // negedge+1, queue expected read data, then advance to posedge+1.
  task automatic run_cycle(input string tag,
                           input logic ireq, input logic [AW-1:0] iaddr,
                           input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                           input logic [3:0] dbe, input logic [31:0] dwd,
                           input logic exp_i, input logic exp_d, input logic [31:0] exp_rd);
    I_REQ = ireq; I_ADDR = iaddr;
    D_REQ = dreq; D_WE = dwe; D_ADDR = daddr; D_BE = dbe; D_WDATA = dwd;
    @(negedge CLK); #1;
    check({tag, "/i_gnt"}, 32'(I_GNT), 32'(exp_i));
    check({tag, "/d_gnt"}, 32'(D_GNT), 32'(exp_d));
    check({tag, "/m_csn"}, 32'(M_CSN), 32'(!(exp_i || exp_d)));
    if (exp_i) begin
      check({tag, "/m_addr_i"}, 32'(M_ADDR), 32'(iaddr));
      check({tag, "/m_wen_i"}, 32'(M_WEN), 32'd1);
      i_q.push_back(exp_rd);
    end
    if (exp_d) begin
      check({tag, "/m_addr_d"}, 32'(M_ADDR), 32'(daddr));
      check({tag, "/m_wen_d"}, 32'(M_WEN), 32'(!dwe));
      check({tag, "/m_be"}, 32'(M_BE), dwe ? 32'(dbe) : 32'd0);
      if (dwe) check({tag, "/m_di"}, M_DI, dwd);
      else     d_q.push_back(exp_rd);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input string tag);
    run_cycle(tag, 1'b0, '0, 1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/m_csn"},    32'(M_CSN), 32'd1);
    check({tag, "/m_wen"},    32'(M_WEN), 32'd1);
    check({tag, "/i_gnt"},    32'(I_GNT), 32'd0);
    check({tag, "/d_gnt"},    32'(D_GNT), 32'd0);
    check({tag, "/i_rvalid"}, 32'(I_RVALID), 32'd0);
    check({tag, "/d_rvalid"}, 32'(D_RVALID), 32'd0);
    check({tag, "/i_cnt"},    32'(I_CNT), 32'd0);
    check({tag, "/d_cnt"},    32'(D_CNT), 32'd0);
    check({tag, "/stall"},    32'(I_STALL_CNT), 32'd0);
  endtask

  task automatic check_counters(input string tag, input int ei, input int ed, input int es);
    check({tag, "/i_cnt"}, 32'(I_CNT), 32'(ei));
    check({tag, "/d_cnt"}, 32'(D_CNT), 32'(ed));
    check({tag, "/stall"}, 32'(I_STALL_CNT), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; load_en = 1'b1;
    I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_BE = '0; D_WDATA = '0;
    repeat (2) @(posedge CLK);
    #1 load_en = 1'b0;
    check_reset_state("reset_init");
    RST = 1'b0;

    // Fetch only: addresses 0..4, data 0x100+addr.
    for (int k = 0; k < 5; k++)
      run_cycle("fetch", 1'b1, AW'(k), 1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h100 + k);
    idle("fetch_drain");
    check_counters("fetch_cnt", 5, 0, 0);

    // Data partial write then read-back of the merged word.
    run_cycle("d_write", 1'b0, '0, 1'b1, 1'b1, AW'('h3A5), 4'b0011, 32'hDEAD_BEEF,
              1'b0, 1'b1, 32'h0);
    run_cycle("d_read", 1'b0, '0, 1'b1, 1'b0, AW'('h3A5), 4'b0000, 32'h0,
              1'b0, 1'b1, 32'h1122_BEEF);
    idle("d_drain");
    idle("d_hold");
    @(negedge CLK); #1;
    check("d_rdata_hold", D_RDATA, 32'h1122_BEEF);
    check("d_rvalid_idle", 32'(D_RVALID), 32'd0);
    check_counters("d_cnt", 5, 2, 0);
    @(posedge CLK); #1;

    // Mid-run reset right after a fetch grant edge: return is discarded.
    run_cycle("rst_pre", 1'b1, AW'(2), 1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h102);
    RST = 1'b1; D_REQ = 1'b1;
    #1;
    i_q.delete();
    check_reset_state("reset_mid");
    @(posedge CLK); #1;
    I_REQ = 0; D_REQ = 0;
    RST = 1'b0;

    // Contention: both held high, expect D,D,D,I repeating.
    for (int c = 0; c < 12; c++) begin
      if (c == 4 || c == 8)
        check("contend_stall_mid", 32'(I_STALL_CNT), 32'(3 * (c / 4)));
      run_cycle("contend", 1'b1, AW'(7), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0,
                (c % 4) == 3, (c % 4) != 3, ((c % 4) == 3) ? 32'h107 : 32'h1122_BEEF);
    end
    idle("contend_drain");
    check_counters("contend_cnt", 3, 9, 9);

    // Cancel: two denied fetch cycles then drop; the wait count must restart,
    // so the renewed fetch still needs three denied cycles.
    run_cycle("cancel0", 1'b1, AW'(5), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_BEEF);
    run_cycle("cancel1", 1'b1, AW'(5), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_BEEF);
    run_cycle("cancel2", 1'b0, AW'(5), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_BEEF);
    run_cycle("cancel3", 1'b0, AW'(5), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0, 1'b0, 1'b1, 32'h1122_BEEF);
    for (int c = 0; c < 4; c++)
      run_cycle("retry", 1'b1, AW'(5), 1'b1, 1'b0, AW'('h3A5), 4'h0, 32'h0,
                c == 3, c != 3, (c == 3) ? 32'h105 : 32'h1122_BEEF);
    idle("cancel_drain");
    // 16 data grants so far wrap the 4-bit D counter to 0.
    check_counters("cancel_cnt", 4, 0, 14);

    // Counter wrap after a fresh reset: 17 data writes.
    RST = 1'b1;
    #1;
    check_reset_state("reset_wrap");
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 17; k++)
      run_cycle("wr_wrap", 1'b0, '0, 1'b1, 1'b1, AW'('h200 + k), 4'hF, 32'(k),
                1'b0, 1'b1, 32'h0);
    idle("wrap_drain");
    check_counters("wrap_cnt", 0, 1, 0);
    run_cycle("rd_last", 1'b0, '0, 1'b1, 1'b0, AW'('h210), 4'h0, 32'h0, 1'b0, 1'b1, 32'h10);
    idle("final_drain");
    idle("final_idle");

    check("i_queue_empty", 32'(i_q.size()), 32'd0);
    check("d_queue_empty", 32'(d_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
